branch_resolve: RTL and testbench

Responder side of the program-counter control-flow handshake. The PC unit drives the instruction address. It reads back the current opcode, and on a control-flow opcode it holds the address for one cycle, then applies `IP + up_amt` when `b_taken` is high. This block supplies that return path:
- opcode echo
- one-cycle resolution of JAL, JALR and the conditional branches (taken flag and signed PC offset)
- link-register write request for jumps

It sits between the fetch stage (instruction word, register-file read data) and the PC unit.

---
 rtl/cf_pkg.sv | 25 ++
 rtl/branch_cmp.sv | 34 +++
 rtl/branch_resolve.sv | 143 ++++++++++++++
 tb/tb_branch_resolve.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cf_pkg.sv
// Shared control-flow definitions for the PC unit and the branch resolver.
// Opcode and funct3 encodings plus the resolver FSM state type.
package cf_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    IDLE    = 1'b0,
    RESOLVE = 1'b1
  } br_state_t;

  function automatic logic is_cf(input logic [6:0] op);
    return (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Conditional-branch comparator: decides the taken flag from funct3 and
// the two register operands. Reserved funct3 encodings never take.
import cf_pkg::*;

module branch_cmp (
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        taken
);

  logic eq_s;
  logic lt_s;
  logic ltu_s;

  assign eq_s  = (rs1 == rs2);
  assign lt_s  = ($signed(rs1) < $signed(rs2));
  assign ltu_s = (rs1 < rs2);

  // funct3 decode onto the three base comparisons
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq_s;
      F3_BNE:  taken = ~eq_s;
      F3_BLT:  taken = lt_s;
      F3_BGE:  taken = ~lt_s;
      F3_BLTU: taken = ltu_s;
      F3_BGEU: taken = ~ltu_s;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Responder side of the PC control-flow handshake: captures a JAL/JALR/branch
// while the PC holds, then presents taken flag, PC offset and link write.
import cf_pkg::*;

module branch_resolve (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTR,
  input  logic [31:0] IP,
  input  logic [31:0] PC_def,
  input  logic [31:0] RS1_DATA,
  input  logic [31:0] RS2_DATA,
  output logic [6:0]  OP,
  output logic [31:0] up_amt,
  output logic        b_taken,
  output logic        link_we,
  output logic [4:0]  link_rd,
  output logic [31:0] link_data,
  output logic        busy
);

  br_state_t   state_q, state_d;
  logic        busy_q, busy_d;
  logic [6:0]  op_q, op_d;
  logic [24:0] ins_q, ins_d;
  logic [31:0] ip_q, ip_d;
  logic [31:0] pcdef_q, pcdef_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;

  logic [31:0] ins_s;
  logic [31:0] j_imm_s;
  logic [31:0] b_imm_s;
  logic [31:0] i_imm_s;
  logic [31:0] jalr_tgt_s;
  logic        cmp_taken_s;

  assign OP = INSTR[6:0];

  // Next-state and capture: operands are latched only on the IDLE trigger
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ins_d   = ins_q;
    ip_d    = ip_q;
    pcdef_d = pcdef_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    case (state_q)
      IDLE: begin
        if (is_cf(OP)) begin
          state_d = RESOLVE;
          op_d    = OP;
          ins_d   = INSTR[31:7];
          ip_d    = IP;
          pcdef_d = PC_def;
          rs1_d   = RS1_DATA;
          rs2_d   = RS2_DATA;
        end else begin
          state_d = IDLE;
        end
      end
      RESOLVE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RESOLVE);
  end

  // State and capture registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      op_q    <= 7'd0;
      ins_q   <= 25'd0;
      ip_q    <= 32'd0;
      pcdef_q <= 32'd0;
      rs1_q   <= 32'd0;
      rs2_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      op_q    <= op_d;
      ins_q   <= ins_d;
      ip_q    <= ip_d;
      pcdef_q <= pcdef_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
    end
  end

  assign busy = busy_q;

  assign ins_s      = {ins_q, op_q};
  assign j_imm_s    = {{12{ins_s[31]}}, ins_s[19:12], ins_s[20], ins_s[30:21], 1'b0};
  assign b_imm_s    = {{20{ins_s[31]}}, ins_s[7], ins_s[30:25], ins_s[11:8], 1'b0};
  assign i_imm_s    = {{20{ins_s[31]}}, ins_s[31:20]};
  assign jalr_tgt_s = (rs1_q + i_imm_s) & 32'hFFFF_FFFE;

  branch_cmp u_cmp (
    .funct3 (ins_s[14:12]),
    .rs1    (rs1_q),
    .rs2    (rs2_q),
    .taken  (cmp_taken_s)
  );

  // Resolution outputs; a RESET in the RESOLVE cycle cancels the link write
  always_comb begin
    b_taken   = 1'b0;
    up_amt    = 32'd0;
    link_we   = 1'b0;
    link_rd   = 5'd0;
    link_data = 32'd0;
    if (state_q == RESOLVE) begin
      case (op_q)
        OP_JAL: begin
          b_taken   = 1'b1;
          up_amt    = j_imm_s;
          link_rd   = ins_s[11:7];
          link_data = pcdef_q;
          link_we   = (ins_s[11:7] != 5'd0) && !RESET;
        end
        OP_JALR: begin
          b_taken   = 1'b1;
          up_amt    = jalr_tgt_s - ip_q;
          link_rd   = ins_s[11:7];
          link_data = pcdef_q;
          link_we   = (ins_s[11:7] != 5'd0) && !RESET;
        end
        OP_BRANCH: begin
          b_taken = cmp_taken_s;
          up_amt  = b_imm_s;
        end
        default: begin
          b_taken = 1'b0;
        end
      endcase
    end else begin
      b_taken = 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: table of single resolves plus
// hand-written multi-cycle sequences (held trigger, back-to-back, reset).
module tb_branch_resolve;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTR, IP, PC_def, RS1_DATA, RS2_DATA;
  logic [6:0]  OP;
  logic [31:0] up_amt, link_data;
  logic        b_taken, link_we, busy;
  logic [4:0]  link_rd;

  int total  = 0;
  int passed = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  branch_resolve dut (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .IP(IP), .PC_def(PC_def),
    .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA), .OP(OP), .up_amt(up_amt),
    .b_taken(b_taken), .link_we(link_we), .link_rd(link_rd),
    .link_data(link_data), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] ip;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        exp_taken;
    logic [31:0] exp_up;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " b_taken"}, {31'd0, b_taken}, 32'd0);
    chk({tag, " up_amt"},  up_amt, 32'd0);
    chk({tag, " link_we"}, {31'd0, link_we}, 32'd0);
    chk({tag, " busy"},    {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    int busy_cnt;

    vecs[0]  = '{"jal+8",     32'h008000EF, 32'h10,   32'h0,        32'h0,        1'b1, 32'h8,        1'b1, 5'd1, 32'h14};
    vecs[1]  = '{"beq eq",    32'hFE208EE3, 32'h40,   32'h5,        32'h5,        1'b1, 32'hFFFFFFFC, 1'b0, 5'd0, 32'h0};
    vecs[2]  = '{"beq ne",    32'hFE208EE3, 32'h40,   32'h5,        32'h6,        1'b0, 32'hFFFFFFFC, 1'b0, 5'd0, 32'h0};
    vecs[3]  = '{"bne",       32'hFE209EE3, 32'h40,   32'h5,        32'h6,        1'b1, 32'hFFFFFFFC, 1'b0, 5'd0, 32'h0};
    vecs[4]  = '{"blt",       32'hFE20CEE3, 32'h40,   32'hFFFFFFFF, 32'h1,        1'b1, 32'hFFFFFFFC, 1'b0, 5'd0, 32'h0};
    vecs[5]  = '{"bltu",      32'hFE20EEE3, 32'h40,   32'hFFFFFFFF, 32'h1,        1'b0, 32'hFFFFFFFC, 1'b0, 5'd0, 32'h0};
    vecs[6]  = '{"bgeu",      32'hFE20FEE3, 32'h40,   32'hFFFFFFFF, 32'h1,        1'b1, 32'hFFFFFFFC, 1'b0, 5'd0, 32'h0};
    vecs[7]  = '{"f3 010",    32'hFE20AEE3, 32'h40,   32'hFFFFFFFF, 32'h1,        1'b0, 32'hFFFFFFFC, 1'b0, 5'd0, 32'h0};
    vecs[8]  = '{"bge",       32'hFE20DEE3, 32'h40,   32'hFFFFFFFF, 32'h1,        1'b0, 32'hFFFFFFFC, 1'b0, 5'd0, 32'h0};
    vecs[9]  = '{"jalr rd0",  32'h00408067, 32'h20,   32'h101,      32'h0,        1'b1, 32'hE4,       1'b0, 5'd0, 32'h24};
    vecs[10] = '{"jalr neg",  32'hFF8082E7, 32'h2000, 32'h1000,     32'h0,        1'b1, 32'hFFFFEFF8, 1'b1, 5'd5, 32'h2004};
    vecs[11] = '{"jal rd0",   32'h0080006F, 32'h10,   32'h0,        32'h0,        1'b1, 32'h8,        1'b0, 5'd0, 32'h14};
    vecs[12] = '{"bltu rev",  32'hFE20EEE3, 32'h40,   32'h1,        32'hFFFFFFFF, 1'b1, 32'hFFFFFFFC, 1'b0, 5'd0, 32'h0};

    RESET = 1'b1; INSTR = 32'h008000EF; IP = 32'h10; PC_def = 32'h14;
    RS1_DATA = 32'h0; RS2_DATA = 32'h0;
    tick(); tick();
    check_idle("reset");
    chk("reset op echo", {25'd0, OP}, 32'h6F);
    INSTR = NOP;
    RESET = 1'b0;
    tick();

    // table-driven single resolves
    for (int k = 0; k < 13; k++) begin
      INSTR = vecs[k].instr; IP = vecs[k].ip; PC_def = vecs[k].ip + 32'd4;
      RS1_DATA = vecs[k].rs1; RS2_DATA = vecs[k].rs2;
      #1;
      w = vecs[k].instr;
      chk({vecs[k].name, " op"}, {25'd0, OP}, {25'd0, w[6:0]});
      tick();
      INSTR = NOP; RS1_DATA = 32'hDEAD_BEEF; RS2_DATA = 32'h1234_5678; IP = 32'h0BAD_0000;
      #1;
      chk({vecs[k].name, " b_taken"}, {31'd0, b_taken}, {31'd0, vecs[k].exp_taken});
      chk({vecs[k].name, " up_amt"}, up_amt, vecs[k].exp_up);
      chk({vecs[k].name, " link_we"}, {31'd0, link_we}, {31'd0, vecs[k].exp_we});
      chk({vecs[k].name, " busy"}, {31'd0, busy}, 32'd1);
      if (vecs[k].exp_we) begin
        chk({vecs[k].name, " link_rd"}, {27'd0, link_rd}, {27'd0, vecs[k].exp_rd});
        chk({vecs[k].name, " link_data"}, link_data, vecs[k].exp_data);
      end
      tick();
      check_idle({vecs[k].name, " after"});
    end

    // JAL held two cycles: exactly one RESOLVE
    busy_cnt = 0;
    INSTR = 32'h008000EF; IP = 32'h10; PC_def = 32'h14;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 1) INSTR = NOP;
      #1;
      if (busy) busy_cnt++;
    end
    chk("held jal resolve count", busy_cnt, 32'd1);

    // back-to-back: JAL at N, BEQ at N+2 resolves at N+3
    INSTR = 32'h008000EF; IP = 32'h10; PC_def = 32'h14;
    tick();
    chk("b2b first busy", {31'd0, busy}, 32'd1);
    tick();
    INSTR = 32'hFE208EE3; IP = 32'h18; PC_def = 32'h1C; RS1_DATA = 32'h7; RS2_DATA = 32'h7;
    #1;
    chk("b2b n+2 busy", {31'd0, busy}, 32'd0);
    tick();
    INSTR = NOP;
    #1;
    chk("b2b n+3 busy", {31'd0, busy}, 32'd1);
    chk("b2b n+3 b_taken", {31'd0, b_taken}, 32'd1);
    chk("b2b n+3 up_amt", up_amt, 32'hFFFFFFFC);
    tick();

    // non-control-flow opcode stays idle
    INSTR = 32'h0000_0033;
    tick();
    check_idle("non-cf");
    tick();
    check_idle("non-cf 2");

    // RESET during RESOLVE of JAL rd=5 drops the link write
    INSTR = 32'h008002EF; IP = 32'h30; PC_def = 32'h34;
    tick();
    RESET = 1'b1;
    #1;
    chk("rst resolve link_we", {31'd0, link_we}, 32'd0);
    chk("rst resolve busy", {31'd0, busy}, 32'd1);
    tick();
    RESET = 1'b0;
    INSTR = NOP;
    #1;
    check_idle("rst after");
    tick();
    check_idle("rst after 2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
